// File: rtl/wb_stage_ctrl.sv
// Registered write-back stage: write-data select, load-data wait, register-file write port, HALT.
// Optional forwarding outputs are enabled by defining WB_FWD_EN.
module wb_stage_ctrl #(
    parameter int unsigned       DATA_W  = 24,
    parameter int unsigned       OPC_W   = 5,
    parameter int unsigned       REG_AW  = 3,
    parameter logic [OPC_W-1:0]  OPC_LD  = OPC_W'(5'b10001),
    parameter int unsigned       TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic              in_wr_en,
    input  logic [REG_AW-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc_add,
    input  logic [DATA_W-1:0] in_result,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              retire,
    output logic              stall,
    output logic              halted,
    output logic              mem_tmo
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] pend_waddr_q, pend_waddr_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              retire_q, retire_d;
    logic              stall_q, stall_d;
    logic              halted_q, halted_d;
    logic              mem_tmo_q, mem_tmo_d;
`ifdef WB_FWD_EN
    logic              fwd_valid_q, fwd_valid_d;
    logic [REG_AW-1:0] fwd_addr_q, fwd_addr_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
`endif

    logic [4:0]        op5;
    logic              is_link, is_lbi, is_ld, is_halt, accept;
    logic [DATA_W-1:0] wdata_sel;

    // Opcode decode is defined on the low five bits only.
    assign op5     = in_opcode[4:0];
    assign is_link = !op5[4] && !op5[3] && op5[1];
    assign is_lbi  = (op5 == 5'b11000);
    assign is_ld   = (in_opcode == OPC_LD);
    assign is_halt = (op5 == 5'b00000);

    assign in_ready = (state_q == S_IDLE) && !halted_q;
    assign accept   = in_valid && in_ready;

    assign wdata_sel = is_link ? in_pc_add :
                       is_lbi  ? in_imm    :
                       is_ld   ? mem_rd_data : in_result;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_waddr_d = pend_waddr_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_d     = 1'b0;
        stall_d      = 1'b0;
        halted_d     = halted_q;
        mem_tmo_d    = mem_tmo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_ld && in_wr_en && !mem_rd_valid) begin
                        state_d      = S_WAIT;
                        pend_waddr_d = in_waddr;
                        cnt_d        = '0;
                        stall_d      = 1'b1;
                    end else begin
                        retire_d = 1'b1;
                        rf_we_d  = in_wr_en && !is_halt;
                        halted_d = halted_q || is_halt;
                        if (in_wr_en && !is_halt) begin
                            rf_waddr_d = in_waddr;
                            rf_wdata_d = wdata_sel;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (mem_rd_valid) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    rf_we_d    = 1'b1;
                    retire_d   = 1'b1;
                    rf_waddr_d = pend_waddr_q;
                    rf_wdata_d = mem_rd_data;
                end else begin
                    stall_d = 1'b1;
                    // Saturating wait counter; timeout flag stays set once reached.
                    if (cnt_q != CNT_W'(TMO_CYC)) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q >= CNT_W'(TMO_CYC - 1)) mem_tmo_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef WB_FWD_EN
    always_comb begin
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        if (rf_we_d) begin
            fwd_valid_d = 1'b1;
            fwd_addr_d  = rf_waddr_d;
            fwd_data_d  = rf_wdata_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_waddr_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retire_q     <= 1'b0;
            stall_q      <= 1'b0;
            halted_q     <= 1'b0;
            mem_tmo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_waddr_q <= pend_waddr_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            retire_q     <= retire_d;
            stall_q      <= stall_d;
            halted_q     <= halted_d;
            mem_tmo_q    <= mem_tmo_d;
        end
    end

`ifdef WB_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_addr  = fwd_addr_q;
    assign fwd_data  = fwd_data_q;
`endif

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign retire   = retire_q;
    assign stall    = stall_q;
    assign halted   = halted_q;
    assign mem_tmo  = mem_tmo_q;

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Directed self-checking bench for wb_stage_ctrl (TMO_CYC=4 so the timeout case is short).
module tb_wb_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic        in_wr_en;
    logic [2:0]  in_waddr;
    logic [23:0] in_imm;
    logic [23:0] in_pc_add;
    logic [23:0] in_result;
    logic        mem_rd_valid;
    logic [23:0] mem_rd_data;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [23:0] rf_wdata;
    logic        retire;
    logic        stall;
    logic        halted;
    logic        mem_tmo;

    int pass_cnt = 0;
    int total_cnt = 0;

    wb_stage_ctrl #(
        .DATA_W(24), .OPC_W(5), .REG_AW(3), .OPC_LD(5'b10001), .TMO_CYC(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_wr_en(in_wr_en), .in_waddr(in_waddr),
        .in_imm(in_imm), .in_pc_add(in_pc_add), .in_result(in_result),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire(retire), .stall(stall), .halted(halted), .mem_tmo(mem_tmo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic we, input logic [2:0] wa,
                         input logic [23:0] imm, input logic [23:0] pc, input logic [23:0] res);
        in_valid  = v;
        in_opcode = op;
        in_wr_en  = we;
        in_waddr  = wa;
        in_imm    = imm;
        in_pc_add = pc;
        in_result = res;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 5'b00100, 1'b0, 3'd0, 24'h0, 24'h0, 24'h0);
        mem_rd_valid = 1'b0;
        mem_rd_data  = 24'h0;
        step(); step();
        rst = 1'b0;
        step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got=%b exp=0", rf_we); else pass_cnt++;
        total_cnt++; if (retire !== 1'b0) $display("FAIL reset_retire got=%b exp=0", retire); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else pass_cnt++;
        total_cnt++; if (mem_tmo !== 1'b0) $display("FAIL reset_mem_tmo got=%b exp=0", mem_tmo); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 24'h0 || rf_waddr !== 3'd0) $display("FAIL reset_rf_bus got=%h/%0d exp=000000/0", rf_wdata, rf_waddr); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    endtask

    task automatic test_link();
        drive(1'b1, 5'b00110, 1'b1, 3'd7, 24'h0, 24'h000102, 24'h555555);
        step();
        in_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1) $display("FAIL link_we got=%b exp=1", rf_we); else pass_cnt++;
        total_cnt++; if (rf_waddr !== 3'd7) $display("FAIL link_addr got=%0d exp=7", rf_waddr); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 24'h000102) $display("FAIL link_data got=%h exp=000102", rf_wdata); else pass_cnt++;
        total_cnt++; if (retire !== 1'b1) $display("FAIL link_retire got=%b exp=1", retire); else pass_cnt++;
        step();
        total_cnt++; if (rf_we !== 1'b0 || retire !== 1'b0) $display("FAIL link_pulse got=%b%b exp=00", rf_we, retire); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 24'h000102) $display("FAIL link_hold got=%h exp=000102", rf_wdata); else pass_cnt++;
    endtask

    task automatic test_lbi();
        drive(1'b1, 5'b11000, 1'b1, 3'd2, 24'hFFFF80, 24'h000010, 24'h333333);
        step();
        in_valid = 1'b0;
        total_cnt++; if (rf_wdata !== 24'hFFFF80) $display("FAIL lbi_data got=%h exp=FFFF80", rf_wdata); else pass_cnt++;
        total_cnt++; if (rf_waddr !== 3'd2) $display("FAIL lbi_addr got=%0d exp=2", rf_waddr); else pass_cnt++;
        total_cnt++; if (retire !== 1'b1 || rf_we !== 1'b1) $display("FAIL lbi_strobes got=%b%b exp=11", retire, rf_we); else pass_cnt++;
    endtask

    task automatic test_alu_and_fast_load();
        // Non-writing instruction retires but leaves the write bus alone.
        drive(1'b1, 5'b00100, 1'b0, 3'd1, 24'h0, 24'h0, 24'h123456);
        step();
        total_cnt++; if (retire !== 1'b1 || rf_we !== 1'b0) $display("FAIL nowr_strobes got=%b%b exp=10", retire, rf_we); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 24'hFFFF80 || rf_waddr !== 3'd2) $display("FAIL nowr_hold got=%h/%0d exp=FFFF80/2", rf_wdata, rf_waddr); else pass_cnt++;
        // op3 set: not a link even though op1 is set, so ALU result is selected.
        drive(1'b1, 5'b01010, 1'b1, 3'd5, 24'h0, 24'h777777, 24'h0A0B0C);
        step();
        total_cnt++; if (rf_wdata !== 24'h0A0B0C || rf_waddr !== 3'd5) $display("FAIL alu_data got=%h/%0d exp=0A0B0C/5", rf_wdata, rf_waddr); else pass_cnt++;
        // Load whose data is already valid completes in one cycle.
        drive(1'b1, 5'b10001, 1'b1, 3'd3, 24'h0, 24'h0, 24'h999999);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 24'h111111;
        step();
        in_valid = 1'b0;
        mem_rd_valid = 1'b0;
        total_cnt++; if (rf_wdata !== 24'h111111 || rf_we !== 1'b1) $display("FAIL fastld_data got=%h we=%b exp=111111 we=1", rf_wdata, rf_we); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0 || in_ready !== 1'b1) $display("FAIL fastld_flow got=%b%b exp=01", stall, in_ready); else pass_cnt++;
    endtask

    task automatic test_load_wait();
        drive(1'b1, 5'b10001, 1'b1, 3'd4, 24'h0, 24'h0, 24'h222222);
        mem_rd_valid = 1'b0;
        step();
        // A new instruction offered while stalled must be ignored.
        drive(1'b1, 5'b00110, 1'b1, 3'd6, 24'h0, 24'h0000AA, 24'h0);
        total_cnt++; if (stall !== 1'b1 || in_ready !== 1'b0) $display("FAIL ldw_stall1 got=%b%b exp=10", stall, in_ready); else pass_cnt++;
        total_cnt++; if (rf_we !== 1'b0 || retire !== 1'b0) $display("FAIL ldw_nowrite got=%b%b exp=00", rf_we, retire); else pass_cnt++;
        step();
        total_cnt++; if (stall !== 1'b1 || in_ready !== 1'b0) $display("FAIL ldw_stall2 got=%b%b exp=10", stall, in_ready); else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++; if (stall !== 1'b1 || rf_we !== 1'b0) $display("FAIL ldw_stall3 got=%b%b exp=10", stall, rf_we); else pass_cnt++;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 24'hABCDEF;
        step();
        mem_rd_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || retire !== 1'b1 || stall !== 1'b0) $display("FAIL ldw_done got=%b%b%b exp=110", rf_we, retire, stall); else pass_cnt++;
        total_cnt++; if (rf_waddr !== 3'd4 || rf_wdata !== 24'hABCDEF) $display("FAIL ldw_bus got=%0d/%h exp=4/ABCDEF", rf_waddr, rf_wdata); else pass_cnt++;
        total_cnt++; if (mem_tmo !== 1'b0) $display("FAIL ldw_tmo got=%b exp=0", mem_tmo); else pass_cnt++;
        step();
        total_cnt++; if (in_ready !== 1'b1 || rf_we !== 1'b0 || retire !== 1'b0) $display("FAIL ldw_after got=%b%b%b exp=100", in_ready, rf_we, retire); else pass_cnt++;
    endtask

    task automatic test_timeout();
        drive(1'b1, 5'b10001, 1'b1, 3'd1, 24'h0, 24'h0, 24'h0);
        mem_rd_valid = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        total_cnt++; if (mem_tmo !== 1'b0) $display("FAIL tmo_early got=%b exp=0 after 3 waits", mem_tmo); else pass_cnt++;
        step();
        total_cnt++; if (mem_tmo !== 1'b1) $display("FAIL tmo_set got=%b exp=1 after 4 waits", mem_tmo); else pass_cnt++;
        step(); step();
        total_cnt++; if (mem_tmo !== 1'b1 || stall !== 1'b1) $display("FAIL tmo_wait6 got=%b%b exp=11", mem_tmo, stall); else pass_cnt++;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 24'h00CAFE;
        step();
        mem_rd_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || rf_wdata !== 24'h00CAFE || rf_waddr !== 3'd1) $display("FAIL tmo_retire got=%b %h/%0d exp=1 00CAFE/1", rf_we, rf_wdata, rf_waddr); else pass_cnt++;
        step();
        total_cnt++; if (mem_tmo !== 1'b1) $display("FAIL tmo_sticky got=%b exp=1", mem_tmo); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        drive(1'b1, 5'b10001, 1'b1, 3'd6, 24'h0, 24'h0, 24'h0);
        mem_rd_valid = 1'b0;
        step();
        in_valid = 1'b0;
        total_cnt++; if (stall !== 1'b1) $display("FAIL rstw_pre got=%b exp=1", stall); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (stall !== 1'b0 || mem_tmo !== 1'b0 || rf_we !== 1'b0) $display("FAIL rstw_async got=%b%b%b exp=000", stall, mem_tmo, rf_we); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 24'h0 || in_ready !== 1'b1) $display("FAIL rstw_bus got=%h rdy=%b exp=000000 rdy=1", rf_wdata, in_ready); else pass_cnt++;
        step();
        rst = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 24'h777777;
        step();
        mem_rd_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b0 || retire !== 1'b0 || rf_wdata !== 24'h0) $display("FAIL rstw_stale got=%b%b %h exp=00 000000", rf_we, retire, rf_wdata); else pass_cnt++;
    endtask

    task automatic test_halt();
        drive(1'b1, 5'b00000, 1'b1, 3'd3, 24'h0, 24'h0, 24'h424242);
        step();
        total_cnt++; if (retire !== 1'b1 || halted !== 1'b1) $display("FAIL halt_retire got=%b%b exp=11", retire, halted); else pass_cnt++;
        total_cnt++; if (rf_we !== 1'b0 || in_ready !== 1'b0) $display("FAIL halt_we_rdy got=%b%b exp=00", rf_we, in_ready); else pass_cnt++;
        drive(1'b1, 5'b00110, 1'b1, 3'd5, 24'h0, 24'h000ABC, 24'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (retire !== 1'b0 || rf_we !== 1'b0 || halted !== 1'b1) $display("FAIL halt_hold%0d got=%b%b%b exp=001", i, retire, rf_we, halted); else pass_cnt++;
        end
        total_cnt++; if (rf_wdata !== 24'h0) $display("FAIL halt_data got=%h exp=000000", rf_wdata); else pass_cnt++;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_link();
        test_lbi();
        test_alu_and_fast_load();
        test_load_wait();
        test_timeout();
        test_reset_in_wait();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
